// File: rtl/alu_arbiter_if.sv
// Request/response bundle between ALU users and the ALU arbiter.
// Requesters drive through master; the arbiter sits on slave.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH_P  = 32,
  parameter int CNTRL_WIDTH_P = 3
);
  logic [1:0]               i_req_valid;
  logic [1:0]               o_req_ready;
  logic [CNTRL_WIDTH_P-1:0] i_req_control_0;
  logic [CNTRL_WIDTH_P-1:0] i_req_control_1;
  logic [DATA_WIDTH_P-1:0]  i_req_a_0;
  logic [DATA_WIDTH_P-1:0]  i_req_a_1;
  logic [DATA_WIDTH_P-1:0]  i_req_b_0;
  logic [DATA_WIDTH_P-1:0]  i_req_b_1;
  logic [1:0]               o_rsp_valid;
  logic [1:0]               i_rsp_ready;
  logic [DATA_WIDTH_P-1:0]  o_rsp_result;
  logic                     o_rsp_error;

  modport master (
    output i_req_valid, i_req_control_0, i_req_control_1,
    output i_req_a_0, i_req_a_1, i_req_b_0, i_req_b_1,
    output i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_error
  );

  modport slave (
    input  i_req_valid, i_req_control_0, i_req_control_1,
    input  i_req_a_0, i_req_a_1, i_req_b_0, i_req_b_1,
    input  i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_error
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sequencing a shared combinational ALU.
// IDLE grants, EXEC drives the ALU, RESP returns the result to the owner.
module alu_arbiter #(
  parameter int DATA_WIDTH_P  = 32,
  parameter int CNTRL_WIDTH_P = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_arbiter_if.slave             bus,
  output logic [CNTRL_WIDTH_P-1:0] o_alu_control,
  output logic [DATA_WIDTH_P-1:0]  o_alu_a,
  output logic [DATA_WIDTH_P-1:0]  o_alu_b,
  input  logic [DATA_WIDTH_P-1:0]  i_alu_result
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [CNTRL_WIDTH_P-1:0] OP_AND = 3'b000;
  localparam logic [CNTRL_WIDTH_P-1:0] OP_OR  = 3'b001;
  localparam logic [CNTRL_WIDTH_P-1:0] OP_ADD = 3'b010;
  localparam logic [CNTRL_WIDTH_P-1:0] OP_SUB = 3'b110;
  localparam logic [CNTRL_WIDTH_P-1:0] OP_SLT = 3'b111;

  state_t                   state_q, state_d;
  logic                     ptr_q;
  logic                     owner_q;
  logic                     err_q;
  logic [CNTRL_WIDTH_P-1:0] ctrl_q;
  logic [DATA_WIDTH_P-1:0]  a_q;
  logic [DATA_WIDTH_P-1:0]  b_q;
  logic [DATA_WIDTH_P-1:0]  res_q;
  logic [1:0]               grant;
  logic                     gidx;
  logic                     legal;
  logic                     take;
  logic [1:0]               req_ready;
  logic [1:0]               rsp_valid;

  // Round-robin: ptr only matters when both requesters contend.
  always_comb begin
    grant = 2'b00;
    case (bus.i_req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign gidx = grant[1];

  always_comb begin
    legal = 1'b0;
    case (ctrl_q)
      OP_AND, OP_OR, OP_ADD,
      OP_SUB, OP_SLT: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (bus.i_rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
    end
  end

  assign take = (state_q == IDLE) && (|grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        ctrl_q  <= gidx ? bus.i_req_control_1 : bus.i_req_control_0;
        a_q     <= gidx ? bus.i_req_a_1 : bus.i_req_a_0;
        b_q     <= gidx ? bus.i_req_b_1 : bus.i_req_b_0;
        owner_q <= gidx;
        ptr_q   <= ~gidx;
      end
      if (state_q == EXEC) begin
        res_q <= legal ? i_alu_result : '0;
        err_q <= ~legal;
      end
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_rsp_result = res_q;
  assign bus.o_rsp_error  = err_q;

  // Gate while reset is high so the ALU sees zeros before the first edge.
  assign o_alu_control = reset ? '0 : ctrl_q;
  assign o_alu_a       = reset ? '0 : a_q;
  assign o_alu_b       = reset ? '0 : b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU.
// Directed requests feed per-requester queues; a monitor checks responses.
module tb_alu_arbiter;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    logic        own;
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [2:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  req_t rq0[$];
  req_t rq1[$];
  exp_t sb[$];

  int applied = 0;
  int miscmp  = 0;

  alu_arbiter_if #(.DATA_WIDTH_P(32), .CNTRL_WIDTH_P(3)) bus ();

  alu_arbiter #(.DATA_WIDTH_P(32), .CNTRL_WIDTH_P(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .o_alu_control (alu_control),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .i_alu_result  (alu_result)
  );

  // Illegal codes return garbage so a missing zero-fill is visible.
  always_comb begin
    alu_result = 32'hDEADBEEF;
    case (alu_control)
      3'b010: alu_result = alu_a + alu_b;
      3'b110: alu_result = alu_a - alu_b;
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b111: alu_result = {31'd0, (alu_a < alu_b)};
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void push(int r, logic [2:0] c, logic [31:0] a,
                               logic [31:0] b);
    req_t q;
    q.c = c;
    q.a = a;
    q.b = b;
    if (r == 0) rq0.push_back(q);
    else rq1.push_back(q);
  endfunction

  function automatic void expect_rsp(logic own, logic [31:0] res, logic err);
    exp_t e;
    e.own = own;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endfunction

  // Requester driver: hold each request until its handshake edge.
  logic [1:0] hs;
  initial begin
    bus.i_req_valid     = 2'b00;
    bus.i_req_control_0 = '0;
    bus.i_req_control_1 = '0;
    bus.i_req_a_0       = '0;
    bus.i_req_a_1       = '0;
    bus.i_req_b_0       = '0;
    bus.i_req_b_1       = '0;
    forever begin
      @(negedge clk);
      hs = bus.i_req_valid & bus.o_req_ready;
      @(posedge clk);
      #1;
      if (hs[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (hs[1] && rq1.size() > 0) void'(rq1.pop_front());
      if (rq0.size() > 0) begin
        bus.i_req_valid[0]  = 1'b1;
        bus.i_req_control_0 = rq0[0].c;
        bus.i_req_a_0       = rq0[0].a;
        bus.i_req_b_0       = rq0[0].b;
      end else begin
        bus.i_req_valid[0] = 1'b0;
      end
      if (rq1.size() > 0) begin
        bus.i_req_valid[1]  = 1'b1;
        bus.i_req_control_1 = rq1[0].c;
        bus.i_req_a_1       = rq1[0].a;
        bus.i_req_b_1       = rq1[0].b;
      end else begin
        bus.i_req_valid[1] = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("ready_rsp_excl",
            32'(|bus.o_req_ready && |bus.o_rsp_valid), 32'd0);
        chk("ready_onehot", 32'($countones(bus.o_req_ready) <= 1), 32'd1);
        if (|bus.o_rsp_valid) begin
          chk("rsp_onehot", 32'($countones(bus.o_rsp_valid)), 32'd1);
          if (|(bus.o_rsp_valid & bus.i_rsp_ready)) begin
            if (sb.size() == 0) begin
              applied++;
              miscmp++;
              $display("FAIL rsp_unexpected: got valid %b expected none",
                       bus.o_rsp_valid);
            end else begin
              e = sb.pop_front();
              chk("rsp_owner", 32'(bus.o_rsp_valid[1]), 32'(e.own));
              chk("rsp_result", bus.o_rsp_result, e.res);
              chk("rsp_error", 32'(bus.o_rsp_error), 32'(e.err));
            end
          end
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      miscmp++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
      rq0.delete();
      rq1.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_ready(input int r, input string nm);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.o_req_ready[r]) break;
      n++;
    end
    if (n >= 50) begin
      miscmp++;
      $display("FAIL %s: got no ready expected ready[%0d]", nm, r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_rsp_ready = 2'b11;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Contention from reset: grants 0,1,0,1.
    push(0, 3'b010, 32'd1, 32'd2);
    push(0, 3'b000, 32'hF0, 32'h3C);
    push(1, 3'b110, 32'd10, 32'd3);
    push(1, 3'b001, 32'h100, 32'h1);
    expect_rsp(1'b0, 32'd3, 1'b0);
    expect_rsp(1'b1, 32'd7, 1'b0);
    expect_rsp(1'b0, 32'h30, 1'b0);
    expect_rsp(1'b1, 32'h101, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_control), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drain();

    // Single ADD with latency check.
    push(0, 3'b010, 32'd5, 32'd7);
    expect_rsp(1'b0, 32'd12, 1'b0);
    wait_ready(0, "add_grant");
    @(negedge clk);
    chk("add_exec_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("add_exec_ctrl", 32'(alu_control), 32'h2);
    chk("add_exec_a", alu_a, 32'd5);
    chk("add_exec_b", alu_b, 32'd7);
    @(negedge clk);
    chk("add_resp_valid", 32'(bus.o_rsp_valid), 32'd1);
    drain();

    // All ops from requester 1.
    push(1, 3'b110, 32'hC, 32'hA);
    push(1, 3'b000, 32'hC, 32'hA);
    push(1, 3'b001, 32'hC, 32'hA);
    push(1, 3'b111, 32'hC, 32'hA);
    push(1, 3'b111, 32'd5, 32'd7);
    expect_rsp(1'b1, 32'd2, 1'b0);
    expect_rsp(1'b1, 32'd8, 1'b0);
    expect_rsp(1'b1, 32'hE, 1'b0);
    expect_rsp(1'b1, 32'd0, 1'b0);
    expect_rsp(1'b1, 32'd1, 1'b0);
    drain();

    // Illegal op, then a normal op to show recovery.
    push(1, 3'b100, 32'd3, 32'd4);
    expect_rsp(1'b1, 32'd0, 1'b1);
    drain();
    push(0, 3'b010, 32'd1, 32'd1);
    expect_rsp(1'b0, 32'd2, 1'b0);
    drain();

    // Backpressure on owner 0 while requester 1 waits.
    @(posedge clk);
    #1 bus.i_rsp_ready = 2'b10;
    push(0, 3'b010, 32'd100, 32'd23);
    expect_rsp(1'b0, 32'd123, 1'b0);
    begin
      int n = 0;
      while (!bus.o_rsp_valid[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        miscmp++;
        $display("FAIL bp_rsp_timeout: got no valid expected valid");
      end
    end
    push(1, 3'b001, 32'hF0, 32'h0F);
    expect_rsp(1'b1, 32'hFF, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("bp_result", bus.o_rsp_result, 32'd123);
      chk("bp_req_ready", 32'(bus.o_req_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.i_rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(bus.o_req_ready), 32'd2);
    drain();

    // Reset during EXEC discards the op and clears ptr.
    push(0, 3'b010, 32'd9, 32'd9);
    wait_ready(0, "rst_mid_grant");
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.o_req_ready), 32'd0);
    chk("mid_rst_alu_ctrl", 32'(alu_control), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("post_rst_alu_a", alu_a, 32'd0);
    chk("post_rst_alu_ctrl", 32'(alu_control), 32'd0);
    push(1, 3'b110, 32'd20, 32'd5);
    push(0, 3'b000, 32'hFF, 32'h0F);
    expect_rsp(1'b0, 32'h0F, 1'b0);
    expect_rsp(1'b1, 32'd15, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule
